// File: rtl/tile_sched_pkg.sv
// tile_sched_pkg: FSM state encoding, default sizes and the index-width helper
// shared by tile_sched and tile_acc.
package tile_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ACC,
    S_EMIT,
    S_DONE
  } state_t;

  localparam int DEF_MAT_R     = 4;
  localparam int DEF_OUT_BITS  = 4;
  localparam int DEF_ROW_TILES = 2;
  localparam int DEF_COL_TILES = 2;
  localparam int DEF_ACC_BITS  = 8;
  localparam int DEF_WAIT_CYC  = 2;

  // Index width; a single-entry range still gets one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tile_acc.sv
// tile_acc: MAT_R-lane load/accumulate register array with sign extension.
// TILE_SCHED_SAT_EN selects a saturating add; otherwise the add wraps.
module tile_acc
  import tile_sched_pkg::*;
#(
  parameter int MAT_R    = DEF_MAT_R,
  parameter int OUT_BITS = DEF_OUT_BITS,
  parameter int ACC_BITS = DEF_ACC_BITS
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               en,
  input  logic                               load,
  input  logic [MAT_R-1:0][OUT_BITS-1:0]     din,
  output logic [MAT_R-1:0][ACC_BITS-1:0]     acc,
  output logic [MAT_R-1:0]                   clamp
);

  for (genvar i = 0; i < MAT_R; i++) begin : g_lane
    logic [ACC_BITS-1:0] ext, nxt, q;

    assign ext = ACC_BITS'($signed(din[i]));

`ifdef TILE_SCHED_SAT_EN
    // One guard bit: overflow when the two top bits of the sum disagree.
    logic [ACC_BITS:0] sum;
    logic              ovf;
    assign sum      = {q[ACC_BITS-1], q} + {ext[ACC_BITS-1], ext};
    assign ovf      = sum[ACC_BITS] ^ sum[ACC_BITS-1];
    assign nxt      = ovf ? {sum[ACC_BITS], {(ACC_BITS-1){~sum[ACC_BITS]}}}
                          : sum[ACC_BITS-1:0];
    assign clamp[i] = en & ~load & ovf;
`else
    assign nxt      = q + ext;
    assign clamp[i] = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
      if (reset)   q <= '0;
      else if (en) q <= load ? ext : nxt;
    end

    assign acc[i] = q;
  end

endmodule

// File: rtl/tile_sched.sv
// tile_sched: walks ROW_TILES x COL_TILES tiles, accumulates engine output per
// row tile and emits result segments. Saturation: define TILE_SCHED_SAT_EN.
module tile_sched
  import tile_sched_pkg::*;
#(
  parameter int MAT_R     = DEF_MAT_R,
  parameter int OUT_BITS  = DEF_OUT_BITS,
  parameter int ROW_TILES = DEF_ROW_TILES,
  parameter int COL_TILES = DEF_COL_TILES,
  parameter int ACC_BITS  = DEF_ACC_BITS,
  parameter int WAIT_CYC  = DEF_WAIT_CYC
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               start,
  output logic                               busy,
  output logic                               done,
  output logic                               tile_rd_en,
  output logic [idx_w(ROW_TILES)-1:0]        tile_row,
  output logic [idx_w(COL_TILES)-1:0]        tile_col,
  input  logic [MAT_R-1:0][OUT_BITS-1:0]     eng_out,
  output logic                               res_valid,
  input  logic                               res_ready,
  output logic [idx_w(ROW_TILES)-1:0]        res_row,
  output logic [MAT_R-1:0][ACC_BITS-1:0]     res_data,
  output logic                               sat_flag
);

  localparam int RW = idx_w(ROW_TILES);
  localparam int CW = idx_w(COL_TILES);
  localparam int WW = idx_w(WAIT_CYC);
  localparam logic [RW-1:0] ROW_LAST  = RW'(ROW_TILES - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(COL_TILES - 1);
  localparam logic [WW-1:0] WAIT_INIT = WW'(WAIT_CYC - 1);

  state_t          state, state_nxt;
  logic [RW-1:0]   row;
  logic [CW-1:0]   col;
  logic [WW-1:0]   wcnt;
  logic [MAT_R-1:0] clamp;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (wcnt == '0) state_nxt = S_ACC;
      S_ACC:   state_nxt = (col == COL_LAST) ? S_EMIT : S_ISSUE;
      S_EMIT:  if (res_ready) state_nxt = (row == ROW_LAST) ? S_DONE : S_ISSUE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != S_IDLE);
    done       = (state == S_DONE);
    tile_rd_en = (state == S_ISSUE);
    res_valid  = (state == S_EMIT);
  end

  // Indices only move on the way into ISSUE, so they double as the held fetch address.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      row  <= '0;
      col  <= '0;
      wcnt <= '0;
    end else begin
      case (state)
        S_IDLE:  if (start) begin row <= '0; col <= '0; end
        S_ISSUE: wcnt <= WAIT_INIT;
        S_WAIT:  if (wcnt != '0) wcnt <= wcnt - 1'b1;
        S_ACC:   if (col != COL_LAST) col <= col + 1'b1;
        S_EMIT:  if (res_ready && row != ROW_LAST) begin
                   row <= row + 1'b1;
                   col <= '0;
                 end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                        sat_flag <= 1'b0;
    else if (state == S_IDLE && start) sat_flag <= 1'b0;
    else if (|clamp)                  sat_flag <= 1'b1;
  end

  assign tile_row = row;
  assign tile_col = col;
  assign res_row  = row;

  tile_acc #(
    .MAT_R    (MAT_R),
    .OUT_BITS (OUT_BITS),
    .ACC_BITS (ACC_BITS)
  ) u_acc (
    .clock (clock),
    .reset (reset),
    .en    (state == S_ACC),
    .load  (col == '0),
    .din   (eng_out),
    .acc   (res_data),
    .clamp (clamp)
  );

endmodule

// File: tb/tb_tile_sched.sv
// tb_tile_sched: directed checks of tile_sched; a second narrow instance
// (ACC_BITS=4) exercises wrap vs. saturation.
module tb_tile_sched;

  localparam int MR = 4;
  localparam int OB = 4;

`ifdef TILE_SCHED_SAT_EN
  localparam int SAT_LANE = 7;
  localparam int SAT_FLAG = 1;
`else
  localparam int SAT_LANE = -2;
  localparam int SAT_FLAG = 0;
`endif

  logic clock = 1'b0, reset = 1'b1, start = 1'b0, res_ready = 1'b1;
  logic busy, done, tile_rd_en, res_valid, sat_flag;
  logic [0:0] tile_row, tile_col, res_row;
  logic [MR-1:0][OB-1:0] eng_out;
  logic [MR-1:0][7:0]    res_data;

  logic start2 = 1'b0, ready2 = 1'b1;
  logic busy2, done2, rd2, rv2, sat2;
  logic [0:0] tr2, tc2, rr2;
  logic [MR-1:0][OB-1:0] eng2;
  logic [MR-1:0][3:0]    data2;

  int tab[2][2];
  int tab2[2];
  int exp_seg[2];
  int n_tests = 0, n_fail = 0;

  tile_sched dut (
    .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
    .tile_rd_en(tile_rd_en), .tile_row(tile_row), .tile_col(tile_col),
    .eng_out(eng_out), .res_valid(res_valid), .res_ready(res_ready),
    .res_row(res_row), .res_data(res_data), .sat_flag(sat_flag)
  );

  tile_sched #(.ROW_TILES(1), .COL_TILES(2), .ACC_BITS(4)) dut2 (
    .clock(clock), .reset(reset), .start(start2), .busy(busy2), .done(done2),
    .tile_rd_en(rd2), .tile_row(tr2), .tile_col(tc2),
    .eng_out(eng2), .res_valid(rv2), .res_ready(ready2),
    .res_row(rr2), .res_data(data2), .sat_flag(sat2)
  );

  always #5 clock = ~clock;

  // Engine model: presents the value of the last fetched tile, held until the next fetch.
  for (genvar l = 0; l < MR; l++) begin : g_eng
    assign eng_out[l] = OB'(tab[tile_row][tile_col]);
    assign eng2[l]    = OB'(tab2[tc2]);
  end

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; start is sampled at the next edge (edge 0).
  task automatic run_job(input bit hold_start, input int stall_len,
                         input int reset_at, input int exp_done);
    int nf = 0, nr = 0, stall = stall_len, done_cyc = -1;
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clock);
      start = hold_start;
      if (k == reset_at) begin
        reset = 1'b1;
        #1;
        check("rst_busy",      int'(busy), 0);
        check("rst_done",      int'(done), 0);
        check("rst_rd_en",     int'(tile_rd_en), 0);
        check("rst_tile_row",  int'(tile_row), 0);
        check("rst_tile_col",  int'(tile_col), 0);
        check("rst_res_valid", int'(res_valid), 0);
        check("rst_res_row",   int'(res_row), 0);
        check("rst_res_data0", int'($signed(res_data[0])), 0);
        check("rst_sat_flag",  int'(sat_flag), 0);
        @(negedge clock);
        reset = 1'b0;
        start = 1'b0;
        return;
      end
      check("busy", int'(busy), 1);
      if (tile_rd_en) begin
        check("fetch_row", int'(tile_row), nf / 2);
        check("fetch_col", int'(tile_col), nf % 2);
        nf++;
      end
      if (res_valid) begin
        check("res_row",   int'(res_row), nr);
        check("res_lane0", int'($signed(res_data[0])), exp_seg[nr]);
        check("res_lane3", int'($signed(res_data[MR-1])), exp_seg[nr]);
        if (stall > 0) begin
          check("stall_rd_en", int'(tile_rd_en), 0);
          res_ready = 1'b0;
          stall--;
        end else begin
          res_ready = 1'b1;
          nr++;
        end
      end
      if (done) begin
        done_cyc = k;
        break;
      end
    end
    check("done_cycle", done_cyc, exp_done);
    check("segments",   nr, 2);
    check("fetches",    nf, 4);
    @(negedge clock);
    start = 1'b0;
    check("idle_busy",  int'(busy), 0);
    check("done_pulse", int'(done), 0);
  endtask

  task automatic run_job2(input int exp_lane, input int exp_sat);
    bit seen = 0;
    start2 = 1'b1;
    @(posedge clock);
    #1 start2 = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clock);
      if (rv2) begin
        check("n_lane0", int'($signed(data2[0])), exp_lane);
        check("n_lane3", int'($signed(data2[MR-1])), exp_lane);
        check("n_sat",   int'(sat2), exp_sat);
        seen = 1;
        break;
      end
    end
    check("n_emit_seen", int'(seen), 1);
    repeat (4) @(negedge clock);
    check("n_idle", int'(busy2), 0);
  endtask

  initial begin
    tab  = '{'{0, 0}, '{0, 0}};
    tab2 = '{0, 0};
    repeat (2) @(negedge clock);
    check("reset_busy",      int'(busy), 0);
    check("reset_rd_en",     int'(tile_rd_en), 0);
    check("reset_res_valid", int'(res_valid), 0);
    check("reset_res_data",  int'($signed(res_data[0])), 0);
    check("reset_sat",       int'(sat_flag), 0);
    reset = 1'b0;
    @(negedge clock);

    // Baseline: 3 per tile, two column tiles -> 6 per lane.
    tab = '{'{3, 3}, '{3, 3}}; exp_seg = '{6, 6};
    run_job(1'b0, 0, 0, 19);

    // Back-to-back job with a 5-cycle consumer stall in the first EMIT.
    run_job(1'b0, 5, 0, 24);

    // Negative mix; second row starts with a load, not an add. start held high throughout.
    tab = '{'{-8, 3}, '{1, 0}}; exp_seg = '{-5, 1};
    run_job(1'b1, 0, 0, 19);

    // Reset during WAIT of tile (1,0), then a fresh full job.
    tab = '{'{2, 2}, '{2, 2}}; exp_seg = '{4, 4};
    run_job(1'b0, 0, 11, 0);
    tab = '{'{2, -1}, '{-4, -4}}; exp_seg = '{1, -8};
    run_job(1'b0, 0, 0, 19);

    // Narrow accumulator: 7 + 7 overflows 4 bits.
    tab2 = '{7, 7};
    run_job2(SAT_LANE, SAT_FLAG);
    check("n_sat_sticky", int'(sat2), SAT_FLAG);
    tab2 = '{1, 1};
    run_job2(2, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
